// File: rtl/inv_mix_columns_iter.sv
// ---------------------------------------------------------------------------
// inv_mix_columns_iter
//
// Purpose:
//   Iterative AES InvMixColumns stage for the decryption datapath. It accepts
//   one 128-bit state per valid/ready handshake. It then transforms LANES
//   columns per clock, in place, in a work register. It presents the finished
//   state with valid/ready back-pressure. A per-block bypass flag lets a block
//   take the same cycle timing while leaving its columns untouched.
//
// Ports:
//   clk            rising-edge clock
//   rst            asynchronous, active-low reset
//   in_valid       input block valid
//   in_ready       block can be accepted (IDLE only, low while in reset)
//   in_bypass      pass block through unmodified, sampled with the data
//   Mixed_Data     input state; byte k = [8k +: 8], column k/4, row k%4
//   out_valid      result valid (DONE state)
//   out_ready      downstream accepts result
//   Inv_Mixed_Data result state, same byte ordering; holds the last result
// ---------------------------------------------------------------------------
module inv_mix_columns_iter #(
    parameter int word_size  = 8,
    parameter int array_size = 16,
    parameter int LANES      = 1
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                in_valid,
    output logic                                in_ready,
    input  logic                                in_bypass,
    input  logic [0:array_size*word_size-1]     Mixed_Data,
    output logic                                out_valid,
    input  logic                                out_ready,
    output logic [0:array_size*word_size-1]     Inv_Mixed_Data
);

    localparam int STATE_W     = array_size * word_size;
    localparam int COL_W       = 4 * word_size;
    localparam int COLS_CYCLES = 4 / LANES;
    localparam int CNT_W       = (COLS_CYCLES > 1) ? $clog2(COLS_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(COLS_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic [CNT_W-1:0]   r_cnt;
    logic [0:STATE_W-1] r_work;
    logic [0:STATE_W-1] r_out;
    logic [0:STATE_W-1] w_work_next;
    logic               r_bypass;

    // Per-lane column selection and transformed result.
    logic [1:0]         w_col_idx [LANES];
    logic [COL_W-1:0]   w_col_in  [LANES];
    logic [COL_W-1:0]   w_col_out [LANES];

    // ------------------------------------------------------------------
    // GF(2^8) helpers
    // ------------------------------------------------------------------
    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1B : 8'h00);
    endfunction

    // Column packed as {a0, a1, a2, a3}, row 0 in the top byte.
    function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
        logic [7:0] a  [4];
        logic [7:0] x2 [4];
        logic [7:0] x4 [4];
        logic [7:0] x8 [4];
        logic [7:0] m9 [4];
        logic [7:0] mb [4];
        logic [7:0] md [4];
        logic [7:0] me [4];
        for (int i = 0; i < 4; i++) begin
            a[i]  = col[31-8*i -: 8];
            x2[i] = xtime(a[i]);
            x4[i] = xtime(x2[i]);
            x8[i] = xtime(x4[i]);
            m9[i] = x8[i] ^ a[i];
            mb[i] = x8[i] ^ x2[i] ^ a[i];
            md[i] = x8[i] ^ x4[i] ^ a[i];
            me[i] = x8[i] ^ x4[i] ^ x2[i];
        end
        return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
                m9[0] ^ me[1] ^ mb[2] ^ md[3],
                md[0] ^ m9[1] ^ me[2] ^ mb[3],
                mb[0] ^ md[1] ^ m9[2] ^ me[3]};
    endfunction

    // ------------------------------------------------------------------
    // Lane datapath: lane gi works on column r_cnt*LANES + gi.
    // ------------------------------------------------------------------
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
        assign w_col_idx[gi] = 2'((int'(r_cnt) * LANES + gi) % 4);
        assign w_col_in[gi]  = r_work[COL_W*w_col_idx[gi] +: COL_W];
        assign w_col_out[gi] = inv_mix_col(w_col_in[gi]);
    end

    // Work register with the current column group replaced. Only consumed
    // while BUSY, so it is not gated on state.
    always_comb begin
        w_work_next = r_work;
        if (!r_bypass) begin
            for (int l = 0; l < LANES; l++) begin
                w_work_next[COL_W*w_col_idx[l] +: COL_W] = w_col_out[l];
            end
        end
    end

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        case (r_state)
            S_IDLE: begin
                // Reset holds the FSM in IDLE, so mask ready while it is asserted.
                in_ready = rst;
                if (in_valid) begin
                    w_state_next = S_BUSY;
                end
            end
            S_BUSY: begin
                if (r_cnt == CNT_LAST) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_work   <= '0;
            r_out    <= '0;
            r_bypass <= 1'b0;
            r_cnt    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_work   <= Mixed_Data;
                        r_bypass <= in_bypass;
                        r_cnt    <= '0;
                    end
                end
                S_BUSY: begin
                    r_work <= w_work_next;
                    if (r_cnt == CNT_LAST) begin
                        // Publish the state including the group finished this edge.
                        r_out <= w_work_next;
                        r_cnt <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign Inv_Mixed_Data = r_out;

endmodule

// File: tb/tb_inv_mix_columns_iter.sv
// ---------------------------------------------------------------------------
// tb_inv_mix_columns_iter
//
// Directed bench for inv_mix_columns_iter. Three instances (LANES = 1, 2, 4)
// share clock, reset, data and out_ready. Each has its own in_valid, and
// cur_sel picks which instance is driven and observed. Inputs change on the
// falling edge and outputs are sampled there too.
// ---------------------------------------------------------------------------
module tb_inv_mix_columns_iter;

    localparam logic [0:127] VEC_IN  = 128'h8e4da1bc_9fdc589d_01010101_d5d5d7d6;
    localparam logic [0:127] VEC_OUT = 128'hdb135345_f20a225c_01010101_d4d4d4d5;
    localparam logic [0:127] VEC_C6  = 128'hc6c6c6c6_c6c6c6c6_c6c6c6c6_c6c6c6c6;

    logic         clk;
    logic         rst;
    logic         iv;
    logic         byp;
    logic [0:127] din;
    logic         ordy;

    logic         iv1, iv2, iv4;
    logic         ir1, ir2, ir4;
    logic         ov1, ov2, ov4;
    logic [0:127] dout1, dout2, dout4;

    logic         sel_ir;
    logic         sel_ov;
    logic [0:127] sel_dout;

    int cur_sel;
    int checks;
    int errors;

    assign iv1 = iv && (cur_sel == 1);
    assign iv2 = iv && (cur_sel == 2);
    assign iv4 = iv && (cur_sel == 4);

    inv_mix_columns_iter #(.word_size(8), .array_size(16), .LANES(1)) u_dut1 (
        .clk(clk), .rst(rst), .in_valid(iv1), .in_ready(ir1), .in_bypass(byp),
        .Mixed_Data(din), .out_valid(ov1), .out_ready(ordy), .Inv_Mixed_Data(dout1)
    );
    inv_mix_columns_iter #(.word_size(8), .array_size(16), .LANES(2)) u_dut2 (
        .clk(clk), .rst(rst), .in_valid(iv2), .in_ready(ir2), .in_bypass(byp),
        .Mixed_Data(din), .out_valid(ov2), .out_ready(ordy), .Inv_Mixed_Data(dout2)
    );
    inv_mix_columns_iter #(.word_size(8), .array_size(16), .LANES(4)) u_dut4 (
        .clk(clk), .rst(rst), .in_valid(iv4), .in_ready(ir4), .in_bypass(byp),
        .Mixed_Data(din), .out_valid(ov4), .out_ready(ordy), .Inv_Mixed_Data(dout4)
    );

    always_comb begin
        sel_ir   = ir1;
        sel_ov   = ov1;
        sel_dout = dout1;
        if (cur_sel == 2) begin
            sel_ir   = ir2;
            sel_ov   = ov2;
            sel_dout = dout2;
        end else if (cur_sel == 4) begin
            sel_ir   = ir4;
            sel_ov   = ov4;
            sel_dout = dout4;
        end
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Reference model: generic shift-and-add GF(2^8) multiply.
    // ------------------------------------------------------------------
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        logic [7:0] bb;
        p  = 8'h00;
        aa = a;
        bb = b;
        for (int i = 0; i < 8; i++) begin
            if (bb[0]) p = p ^ aa;
            aa = aa[7] ? ((aa << 1) ^ 8'h1B) : (aa << 1);
            bb = bb >> 1;
        end
        return p;
    endfunction

    function automatic logic [0:127] ref_mix(input logic [0:127] s);
        logic [7:0]   coef [4];
        logic [7:0]   acc;
        logic [0:127] r;
        coef[0] = 8'h0e;
        coef[1] = 8'h0b;
        coef[2] = 8'h0d;
        coef[3] = 8'h09;
        r = '0;
        for (int c = 0; c < 4; c++) begin
            for (int row = 0; row < 4; row++) begin
                acc = 8'h00;
                for (int j = 0; j < 4; j++) begin
                    acc = acc ^ gmul(coef[(j - row + 4) % 4], s[8*(4*c+j) +: 8]);
                end
                r[8*(4*c+row) +: 8] = acc;
            end
        end
        return r;
    endfunction

    // ------------------------------------------------------------------
    // Stimulus helpers (drive only)
    // ------------------------------------------------------------------
    // Presents a block and returns at the falling edge after acceptance.
    task automatic accept_block(input logic [0:127] d, input logic b, output logic ok);
        int n;
        @(negedge clk);
        din = d;
        byp = b;
        iv  = 1'b1;
        n   = 0;
        while (!sel_ir && n < 20) begin
            @(negedge clk);
            n++;
        end
        ok = sel_ir;
        @(posedge clk);
        @(negedge clk);
        iv = 1'b0;
    endtask

    // Counts falling edges until out_valid is seen (bounded).
    task automatic wait_valid(output int n);
        n = 0;
        while (!sel_ov && n < 20) begin
            @(negedge clk);
            n++;
        end
    endtask

    // ------------------------------------------------------------------
    // Tests
    // ------------------------------------------------------------------
    task automatic test_reset();
        checks++;
        if (sel_ov !== 1'b0) begin errors++; $display("FAIL reset_ov: got %b want 0", sel_ov); end
        checks++;
        if (sel_ir !== 1'b0) begin errors++; $display("FAIL reset_ir: got %b want 0", sel_ir); end
        checks++;
        if (sel_dout !== 128'h0) begin errors++; $display("FAIL reset_dout: got %h want 0", sel_dout); end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (sel_ir !== 1'b1) begin errors++; $display("FAIL reset_release_ir: got %b want 1", sel_ir); end
    endtask

    task automatic test_single();
        logic ok;
        int   n;
        ordy = 1'b1;
        accept_block(VEC_IN, 1'b0, ok);
        checks++;
        if (ok !== 1'b1) begin errors++; $display("FAIL single_accept: got %b want 1", ok); end
        wait_valid(n);
        checks++;
        if (n != 4) begin errors++; $display("FAIL single_latency: got %0d want 4", n); end
        checks++;
        if (sel_dout !== VEC_OUT) begin errors++; $display("FAIL single_data: got %h want %h", sel_dout, VEC_OUT); end
        @(negedge clk);
        checks++;
        if (sel_ov !== 1'b0 || sel_ir !== 1'b1) begin
            errors++;
            $display("FAIL single_post: got ov=%b ir=%b want ov=0 ir=1", sel_ov, sel_ir);
        end
        $display("single block: out=%h", sel_dout);
    endtask

    task automatic test_backpressure();
        logic ok;
        int   n;
        ordy = 1'b0;
        accept_block(VEC_IN, 1'b0, ok);
        wait_valid(n);
        checks++;
        if (n != 4) begin errors++; $display("FAIL bp_latency: got %0d want 4", n); end
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (sel_ov !== 1'b1 || sel_ir !== 1'b0 || sel_dout !== VEC_OUT) begin
                errors++;
                $display("FAIL bp_hold[%0d]: got ov=%b ir=%b data=%h want ov=1 ir=0 data=%h",
                         i, sel_ov, sel_ir, sel_dout, VEC_OUT);
            end
            @(negedge clk);
        end
        ordy = 1'b1;
        @(negedge clk);
        checks++;
        if (sel_ov !== 1'b0 || sel_ir !== 1'b1) begin
            errors++;
            $display("FAIL bp_release: got ov=%b ir=%b want ov=0 ir=1", sel_ov, sel_ir);
        end
        checks++;
        if (sel_dout !== VEC_OUT) begin errors++; $display("FAIL bp_hold_after: got %h want %h", sel_dout, VEC_OUT); end
        $display("back-pressure block: out=%h", sel_dout);
    endtask

    task automatic test_bypass();
        logic ok;
        int   n;
        accept_block(VEC_IN, 1'b1, ok);
        wait_valid(n);
        checks++;
        if (n != 4) begin errors++; $display("FAIL bypass_latency: got %0d want 4", n); end
        checks++;
        if (sel_dout !== VEC_IN) begin errors++; $display("FAIL bypass_data: got %h want %h", sel_dout, VEC_IN); end
        @(negedge clk);
        $display("bypass block: out=%h", sel_dout);
    endtask

    task automatic test_reset_busy();
        logic ok;
        accept_block(VEC_OUT, 1'b0, ok);
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if (sel_ov !== 1'b0 || sel_ir !== 1'b0) begin
            errors++;
            $display("FAIL async_reset_ctl: got ov=%b ir=%b want ov=0 ir=0", sel_ov, sel_ir);
        end
        checks++;
        if (sel_dout !== 128'h0) begin errors++; $display("FAIL async_reset_dout: got %h want 0", sel_dout); end
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checks++;
            if (sel_ir !== 1'b1 || sel_ov !== 1'b0) begin
                errors++;
                $display("FAIL idle_after_reset[%0d]: got ir=%b ov=%b want ir=1 ov=0", i, sel_ir, sel_ov);
            end
        end
        $display("reset mid-busy: out=%h", sel_dout);
    endtask

    task automatic test_reset_cnt2();
        logic         ok;
        int           pulses;
        logic [0:127] got;
        accept_block(VEC_IN, 1'b0, ok);
        @(negedge clk);
        @(negedge clk);
        #2;
        rst = 1'b0;
        #2;
        @(negedge clk);
        rst = 1'b1;
        accept_block(VEC_C6, 1'b0, ok);
        checks++;
        if (ok !== 1'b1) begin errors++; $display("FAIL abort_accept: got %b want 1", ok); end
        pulses = 0;
        got    = '0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (sel_ov) begin
                pulses++;
                got = sel_dout;
            end
        end
        checks++;
        if (pulses != 1) begin errors++; $display("FAIL abort_pulses: got %0d want 1", pulses); end
        checks++;
        if (got !== VEC_C6) begin errors++; $display("FAIL abort_data: got %h want %h", got, VEC_C6); end
        $display("reset at counter 2: pulses=%0d out=%h", pulses, got);
    endtask

    task automatic test_lanes(input int s);
        logic         ok;
        int           n;
        int           cols;
        int           accepted;
        int           received;
        int           last_acc;
        int           cyc;
        logic         pend;
        logic [0:127] q [$];
        cols    = 4 / s;
        cur_sel = s;
        ordy    = 1'b1;
        accept_block(VEC_IN, 1'b0, ok);
        wait_valid(n);
        checks++;
        if (n != cols) begin errors++; $display("FAIL lanes%0d_latency: got %0d want %0d", s, n, cols); end
        checks++;
        if (sel_dout !== VEC_OUT) begin
            errors++;
            $display("FAIL lanes%0d_data: got %h want %h", s, sel_dout, VEC_OUT);
        end
        $display("lanes=%0d vector: latency=%0d out=%h", s, n, sel_dout);
        @(negedge clk);

        // Back-to-back random blocks with out_ready held high.
        accepted = 0;
        received = 0;
        last_acc = -1;
        cyc      = 0;
        pend     = 1'b0;
        din      = {$urandom(), $urandom(), $urandom(), $urandom()};
        byp      = 1'($urandom_range(0, 1));
        iv       = 1'b1;
        while (received < 20 && cyc < 400) begin
            if (pend) begin
                if (accepted < 20) begin
                    din = {$urandom(), $urandom(), $urandom(), $urandom()};
                    byp = 1'($urandom_range(0, 1));
                end else begin
                    iv = 1'b0;
                end
                pend = 1'b0;
            end
            if (sel_ov) begin
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL lanes%0d_spurious: got %h want no output", s, sel_dout);
                end else begin
                    if (sel_dout !== q[0]) begin
                        errors++;
                        $display("FAIL lanes%0d_rand[%0d]: got %h want %h", s, received, sel_dout, q[0]);
                    end
                    $display("lanes=%0d block %0d: out=%h", s, received, sel_dout);
                    void'(q.pop_front());
                end
                received++;
            end
            if (iv && sel_ir) begin
                q.push_back(byp ? din : ref_mix(din));
                if (last_acc >= 0) begin
                    checks++;
                    if (cyc - last_acc != cols + 2) begin
                        errors++;
                        $display("FAIL lanes%0d_period: got %0d want %0d", s, cyc - last_acc, cols + 2);
                    end
                end
                last_acc = cyc;
                accepted++;
                pend = 1'b1;
            end
            @(negedge clk);
            cyc++;
        end
        iv = 1'b0;
        checks++;
        if (received != 20) begin errors++; $display("FAIL lanes%0d_count: got %0d want 20", s, received); end
        @(negedge clk);
    endtask

    // ------------------------------------------------------------------
    // Sequence
    // ------------------------------------------------------------------
    initial begin
        checks  = 0;
        errors  = 0;
        cur_sel = 1;
        rst     = 1'b0;
        iv      = 1'b0;
        byp     = 1'b0;
        din     = '0;
        ordy    = 1'b1;
        #3;
        test_reset();
        test_single();
        test_backpressure();
        test_bypass();
        test_reset_busy();
        test_reset_cnt2();
        test_lanes(4);
        test_lanes(2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: got no finish want finish before 500000");
        $fatal(1, "timeout");
    end

endmodule
